sn76489_reg_ctrl: RTL and testbench
===================================

Name: sn76489_reg_ctrl

Overview:
- Host-side register controller for the SN76489-compatible PSG.
- Accepts byte writes on an 8-bit bus qualified by an asynchronous active-low write strobe. Decodes SN76489 LATCH/DATA byte protocol.
- Owns the 8 PSG control registers (4 attenuation, 3 tone frequency, 1 noise control) and drives them into the tone/noise generators. Replaces hard-coded reset values in the top level.
- Issues a one-cycle LFSR reset pulse to the noise generator on every noise-register write.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on we_n (min 2)
- NUM_TONES, 3, tone channels; channel index NUM_TONES is the noise channel
- TONE_FREQUENCY_BITS, 10, tone period register width
- ATTENUATION_CONTROL_BITS, 4, attenuation register width
- NOISE_CONTROL_BITS, 3, noise register width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- data_in  in  8  host data byte; must be stable while we_n low and for SYNC_STAGES+2 clk after we_n falls
- we_n  in  1  asynchronous active-low write strobe
- attn  out  4*ATTENUATION_CONTROL_BITS  channel k attenuation at [4k+3:4k]; channel 3 = noise
- tone_freq  out  NUM_TONES*TONE_FREQUENCY_BITS  tone k period at [10k+9:10k]
- noise_ctrl  out  NOISE_CONTROL_BITS  bit2 = white(1)/periodic(0), bits1:0 = rate
- noise_reset  out  1  one-cycle pulse; drives noise generator reset_lfsr
- wr_pulse  out  1  one-cycle pulse marking each accepted byte (debug/verification)

Behaviour:
- Reset values: attn all 4'hF (silent); tone_freq all 0; noise_ctrl 0; noise_reset 0; wr_pulse 0; latched channel 0; latched type tone; sync stages and edge-history flop all 1 (idle high).
- Strobe path: we_n passes through SYNC_STAGES flops, then one history flop. fall = history & ~sync_last.
  - Exactly one write per falling edge, however long we_n stays low.
  - we_n glitches shorter than one clk period may be missed. No requirement either way.
- Latency: count clk edges from the first edge that samples we_n low as edge 1. fall is true after edge SYNC_STAGES. Registers, wr_pulse and noise_reset update at edge SYNC_STAGES+1. With default SYNC_STAGES=2, this is edge 3.
- data_in is sampled unsynchronized in the fall cycle.
- LATCH byte (data_in[7]=1): ch = data_in[6:5], type = data_in[4] (1 = volume, 0 = tone/noise). ch and type are stored as the latched target.
  - type=1: attn[ch] <= data_in[3:0].
  - type=0, ch<3: tone_freq[ch][3:0] <= data_in[3:0]; upper bits unchanged.
  - type=0, ch=3: noise_ctrl <= data_in[2:0]; pulse noise_reset.
- DATA byte (data_in[7]=0): applies to the latched target. The latch is unchanged.
  - Volume: attn <= data_in[3:0].
  - Tone: tone_freq[9:4] <= data_in[5:0]; bits 3:0 unchanged.
  - Noise: noise_ctrl <= data_in[2:0]; pulse noise_reset.
  - data_in[6] is ignored.
- noise_reset: high for exactly the one cycle following the write edge, then low. Back-to-back noise writes give separate pulses.
- wr_pulse: high for one cycle on every accepted byte, aligned with the register update.
- Register outputs are flops. Only the addressed register changes on a write; all others hold.
- Reset mid-operation: all state returns to reset values the next edge. A pending edge in the synchronizer is discarded.
  - If we_n is held low across reset release, it is recognised as one write at edge SYNC_STAGES+1 after release.
- Unaddressed writes do not exist: every byte maps to a defined register.

Test Plan:
- Reset -> attn = 16'hFFFF, tone_freq = 0, noise_ctrl = 0, noise_reset = 0, wr_pulse = 0.
- Write 0xAB, then 0x2A (tone ch1) -> tone_freq[19:10] = 10'h2AB; other tones 0; wr_pulse pulses twice; noise_reset stays 0.
- Write 0xD5 (vol ch2 = 5), then DATA 0x03 -> attn[11:8] = 5 after the first byte and 3 after the second; attn[3:0], attn[7:4] and attn[15:12] stay F.
- Write 0xE5 (noise) -> noise_ctrl = 3'b101; noise_reset high for exactly 1 cycle at edge 3 after we_n low. Then DATA 0x06 -> noise_ctrl = 3'b110 and a second noise_reset pulse.
- Timing with we_n held low for 20 cycles, then a 1-cycle-low strobe -> exactly one wr_pulse each. Update occurs on edge 3 after the first low sample; no update before it.
- Assert reset between the LATCH 0x8F (tone0 low nibble = F) write and the DATA write -> tone_freq[9:0] = 0 and latch = ch0/tone. A subsequent 0x01 write gives tone_freq[9:0] = 10'h010.

Source files
------------

// File: rtl/sn76489_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sn76489_reg_ctrl
//  Description : Host-side register controller for an SN76489-compatible PSG.
//                It synchronises an asynchronous active-low write strobe and
//                turns each falling edge into exactly one byte write. It
//                decodes the LATCH/DATA byte protocol and owns the eight PSG
//                control registers:
//                  - four attenuation registers
//                  - three tone-period registers
//                  - one noise-control register
//                Every noise-register write also produces a one-cycle LFSR
//                reset pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock
//    reset       in   synchronous, active-high reset
//    data_in     in   host data byte, sampled unsynchronised in the fall cycle
//    we_n        in   asynchronous active-low write strobe
//    attn        out  attenuation, channel k at [4k+3:4k]; channel 3 = noise
//    tone_freq   out  tone k period at [10k+9:10k]
//    noise_ctrl  out  bit2 white(1)/periodic(0), bits1:0 rate
//    noise_reset out  one-cycle pulse on every noise-register write
//    wr_pulse    out  one-cycle pulse per accepted byte, aligned with update
// ============================================================================
module sn76489_reg_ctrl #(
    parameter int SYNC_STAGES              = 2,
    parameter int NUM_TONES                = 3,
    parameter int TONE_FREQUENCY_BITS      = 10,
    parameter int ATTENUATION_CONTROL_BITS = 4,
    parameter int NOISE_CONTROL_BITS       = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [7:0]                            data_in,
    input  logic                                  we_n,
    output logic [4*ATTENUATION_CONTROL_BITS-1:0] attn,
    output logic [NUM_TONES*TONE_FREQUENCY_BITS-1:0] tone_freq,
    output logic [NOISE_CONTROL_BITS-1:0]         noise_ctrl,
    output logic                                  noise_reset,
    output logic                                  wr_pulse
);

    // Channel index equal to the tone count addresses the noise channel.
    localparam logic [1:0] c_NOISE_CH = 2'(NUM_TONES);

    // Strobe synchroniser and edge detection.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_fall;

    // Latched target of the most recent LATCH byte.
    logic [1:0] r_lch;
    logic       r_ltype;   // 1 = volume, 0 = tone/noise

    // Register file.
    logic [ATTENUATION_CONTROL_BITS-1:0] r_attn [0:3];
    logic [TONE_FREQUENCY_BITS-1:0]      r_tone [0:NUM_TONES-1];
    logic [NOISE_CONTROL_BITS-1:0]       r_noise;
    logic                                r_noise_rst;
    logic                                r_wr;

    // Decode of the current byte's target.
    logic       w_is_latch;
    logic [1:0] w_ch;
    logic       w_vol;
    logic       w_noise_tgt;

    // History flop sits after the last sync stage.
    // A high-to-low step between them is one write, so a strobe held low
    // for a long time is still counted once.
    assign w_fall = r_hist & ~r_sync[SYNC_STAGES-1];

    // DATA bytes reuse the stored target. LATCH bytes supply their own.
    assign w_is_latch  = data_in[7];
    assign w_ch        = w_is_latch ? data_in[6:5] : r_lch;
    assign w_vol       = w_is_latch ? data_in[4]   : r_ltype;
    assign w_noise_tgt = ~w_vol && (w_ch == c_NOISE_CH);

    always_ff @(posedge clk) begin
        if (reset) begin
            // Idle-high preload: a pending strobe edge is discarded.
            // A strobe held low across release is seen as a fresh fall.
            r_sync      <= '1;
            r_hist      <= 1'b1;
            r_lch       <= 2'd0;
            r_ltype     <= 1'b0;
            r_noise     <= '0;
            r_noise_rst <= 1'b0;
            r_wr        <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_attn[k] <= '1;
            end
            for (int k = 0; k < NUM_TONES; k++) begin
                r_tone[k] <= '0;
            end
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], we_n};
            r_hist      <= r_sync[SYNC_STAGES-1];
            r_wr        <= w_fall;
            r_noise_rst <= w_fall & w_noise_tgt;

            if (w_fall) begin
                if (w_is_latch) begin
                    r_lch   <= data_in[6:5];
                    r_ltype <= data_in[4];
                end

                if (w_vol) begin
                    r_attn[w_ch] <= ATTENUATION_CONTROL_BITS'(data_in[3:0]);
                end else if (w_noise_tgt) begin
                    r_noise <= NOISE_CONTROL_BITS'(data_in[2:0]);
                end else if (w_is_latch) begin
                    // LATCH carries the low nibble of the tone period.
                    r_tone[w_ch][3:0] <= data_in[3:0];
                end else begin
                    // DATA carries the upper bits. data_in[6] is ignored.
                    r_tone[w_ch][TONE_FREQUENCY_BITS-1:4] <=
                        (TONE_FREQUENCY_BITS-4)'(data_in[5:0]);
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < 4; k++) begin : g_attn
            assign attn[k*ATTENUATION_CONTROL_BITS +: ATTENUATION_CONTROL_BITS] = r_attn[k];
        end
        for (genvar k = 0; k < NUM_TONES; k++) begin : g_tone
            assign tone_freq[k*TONE_FREQUENCY_BITS +: TONE_FREQUENCY_BITS] = r_tone[k];
        end
    endgenerate

    assign noise_ctrl  = r_noise;
    assign noise_reset = r_noise_rst;
    assign wr_pulse    = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_sn76489_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sn76489_reg_ctrl
//  Description : Scoreboard bench for sn76489_reg_ctrl.
//                Directed byte writes push hand-computed register images into
//                a queue. A monitor pops one image per wr_pulse and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sn76489_reg_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  data_in;
    logic        we_n;
    logic [15:0] attn;
    logic [29:0] tone_freq;
    logic [2:0]  noise_ctrl;
    logic        noise_reset;
    logic        wr_pulse;

    typedef struct packed {
        logic [15:0] a;
        logic [29:0] t;
        logic [2:0]  n;
        logic        nr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    sn76489_reg_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .we_n       (we_n),
        .attn       (attn),
        .tone_freq  (tone_freq),
        .noise_ctrl (noise_ctrl),
        .noise_reset(noise_reset),
        .wr_pulse   (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: one expected image per wr_pulse.
    // A noise_reset without wr_pulse is an error.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_pulse) begin
                if (q.size() == 0) begin
                    check("unexpected_wr_pulse", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sb_attn",        32'(attn),        32'(e.a));
                    check("sb_tone_freq",   32'(tone_freq),   32'(e.t));
                    check("sb_noise_ctrl",  32'(noise_ctrl),  32'(e.n));
                    check("sb_noise_reset", 32'(noise_reset), 32'(e.nr));
                end
            end else if (noise_reset) begin
                check("stray_noise_reset", 32'd1, 32'd0);
            end
        end
    end

    // Called at the negedge where we_n has just been driven low.
    // Holds we_n low for 'low' cycles.
    // wr_pulse must stay low after edges 1 and 2 and be high after edge 3.
    task automatic strobe_from_low(input int low);
        int n;
        n = (low > 3) ? low : 3;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == low) we_n = 1'b1;
            if (k <= 3) check($sformatf("latency_edge%0d", k), 32'(wr_pulse), (k == 3) ? 32'd1 : 32'd0);
        end
        we_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b, input int low,
                              input logic [15:0] ea, input logic [29:0] et,
                              input logic [2:0] en, input logic enr);
        q.push_back('{a: ea, t: et, n: en, nr: enr});
        @(negedge clk);
        data_in = b;
        we_n    = 1'b0;
        strobe_from_low(low);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_attn"},        32'(attn),        32'h0000_FFFF);
        check({tag, "_tone_freq"},   32'(tone_freq),   32'h0);
        check({tag, "_noise_ctrl"},  32'(noise_ctrl),  32'h0);
        check({tag, "_noise_reset"}, 32'(noise_reset), 32'h0);
        check({tag, "_wr_pulse"},    32'(wr_pulse),    32'h0);
    endtask

    initial begin
        reset   = 1'b1;
        we_n    = 1'b1;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("idle");

        // Tone ch1 = 0x2AB, built from a LATCH byte then a DATA byte.
        write_byte(8'hAB, 1, 16'hFFFF, 30'h0002C00, 3'b000, 1'b0);
        write_byte(8'h2A, 1, 16'hFFFF, 30'h00AAC00, 3'b000, 1'b0);
        // Volume ch2 = 5, then DATA 3.
        write_byte(8'hD5, 1, 16'hF5FF, 30'h00AAC00, 3'b000, 1'b0);
        write_byte(8'h03, 1, 16'hF3FF, 30'h00AAC00, 3'b000, 1'b0);
        // Noise LATCH, then noise DATA. Each write gives its own noise_reset.
        write_byte(8'hE5, 1, 16'hF3FF, 30'h00AAC00, 3'b101, 1'b1);
        write_byte(8'h06, 1, 16'hF3FF, 30'h00AAC00, 3'b110, 1'b1);
        // Long low strobe for 20 cycles: vol ch0 = A. Then a 1-cycle strobe: DATA C.
        write_byte(8'h9A, 20, 16'hF3FA, 30'h00AAC00, 3'b110, 1'b0);
        write_byte(8'h1C, 1, 16'hF3FC, 30'h00AAC00, 3'b110, 1'b0);
        // Tone0 low nibble F, then reset wipes everything including the latch.
        write_byte(8'h8F, 1, 16'hF3FC, 30'h00AAC0F, 3'b110, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        // DATA 0x01 goes to the default latch (ch0 tone): tone0 = 0x010.
        write_byte(8'h01, 1, 16'hFFFF, 30'h0000010, 3'b000, 1'b0);
        // we_n held low across reset release counts as one write, edge 3 after release.
        @(negedge clk);
        reset   = 1'b1;
        data_in = 8'h85;
        we_n    = 1'b0;
        repeat (3) @(negedge clk);
        q.push_back('{a: 16'hFFFF, t: 30'h0000005, n: 3'b000, nr: 1'b0});
        reset = 1'b0;
        strobe_from_low(1);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
